branch_resolution_queue: RTL

Tracks every predicted branch from fetch/dispatch until execute resolves it. The block is the consumer side of the branch predictor's predict/train/recover interface. It stores each branch's PC, predicted direction/target and GHR snapshot, compares them against the execute outcome, and drives the predictor's recover port immediately on a mispredict. It squashes younger in-flight branches and emits predictor training in program order.

---
 rtl/bp_pkg.sv | 20 ++
 rtl/branch_resolution_queue_check.sv | 24 ++
 rtl/branch_resolution_queue.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-queue types (entry record, tag) and the mispredict rule
package bp_pkg;
  localparam int BP_GH = 8;
  localparam int BP_DEPTH = 8;
  typedef logic [$clog2(BP_DEPTH)-1:0] brq_tag_t;
  typedef struct packed {
    logic valid;
    logic resolved;
    logic [31:0] pc;
    logic pred_taken;
    logic [31:0] pred_target;
    logic [BP_GH-1:0] ghr;
    logic act_taken;
    logic [31:0] act_target;
  } brq_entry_t;
  function automatic logic is_mispredict(input logic pred_taken, input logic [31:0] pred_target,
                                         input logic act_taken, input logic [31:0] act_target);
    return (pred_taken != act_taken) || (pred_taken && act_taken && pred_target != act_target);
  endfunction
endpackage

// File: rtl/branch_resolution_queue_check.sv
// branch_outcome_check: entry + resolve outcome -> accept, mispredict, corrected ghr, redirect pc, resolved entry
module branch_outcome_check
  import bp_pkg::*;
(
  input  brq_entry_t        entry_i,
  input  logic              resolve_taken_i,
  input  logic [31:0]       resolve_target_i,
  output logic              accept_o,
  output logic              mispredict_o,
  output logic [BP_GH-1:0]  ghr_o,
  output logic [31:0]       pc_o,
  output brq_entry_t        upd_o
);
  always_comb begin
    upd_o = entry_i;
    upd_o.resolved = 1'b1;
    upd_o.act_taken = resolve_taken_i;
    upd_o.act_target = resolve_target_i;
  end
  assign accept_o = entry_i.valid & ~entry_i.resolved;
  assign mispredict_o = is_mispredict(entry_i.pred_taken, entry_i.pred_target, resolve_taken_i, resolve_target_i);
  assign ghr_o = {entry_i.ghr[BP_GH-2:0], resolve_taken_i};
  assign pc_o = resolve_taken_i ? resolve_target_i : entry_i.pc + 32'd4;
endmodule

// File: rtl/branch_resolution_queue.sv
// branch_resolution_queue: in-flight branch tracker; alloc_* in, resolve_* in, train_* pulse out in order, recover_* out on mispredict
module branch_resolution_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GH = BP_GH,
  localparam int TAG_BITS = $clog2(DEPTH)
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                alloc_valid_i,
  input  logic [31:0]         alloc_pc_i,
  input  logic                alloc_pred_taken_i,
  input  logic [31:0]         alloc_pred_target_i,
  input  logic [GH-1:0]       alloc_ghr_snapshot_i,
  output logic                alloc_ready_o,
  output logic [TAG_BITS-1:0] alloc_tag_o,
  input  logic                resolve_valid_i,
  input  logic [TAG_BITS-1:0] resolve_tag_i,
  input  logic                resolve_taken_i,
  input  logic [31:0]         resolve_target_i,
  output logic                train_valid_o,
  output logic [31:0]         train_pc_o,
  output logic                train_actual_taken_o,
  output logic [31:0]         train_actual_target_o,
  output logic [GH-1:0]       train_ghr_snapshot_o,
  output logic                recover_mispredict_pulse_o,
  output logic [GH-1:0]       recover_ghr_snapshot_o,
  output logic [31:0]         recover_pc_o,
  output logic [TAG_BITS-1:0] recover_tag_o
);
  localparam int PW = TAG_BITS + 1;
  brq_entry_t ent_q [DEPTH];
  brq_entry_t ent_d [DEPTH];
  brq_entry_t upd;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_BITS-1:0] hidx, tidx, rage;
  logic accept, misp, acc, mp, pop;
  logic [GH-1:0] chk_ghr;
  logic [31:0] chk_pc;
  logic train_valid_q, train_valid_d, train_taken_q, train_taken_d;
  logic [31:0] train_pc_q, train_pc_d, train_target_q, train_target_d;
  logic [GH-1:0] train_ghr_q, train_ghr_d, rec_ghr_q, rec_ghr_d;
  logic rec_pulse_q, rec_pulse_d;
  logic [31:0] rec_pc_q, rec_pc_d;
  logic [TAG_BITS-1:0] rec_tag_q, rec_tag_d;
  branch_outcome_check u_check (
    .entry_i          (ent_q[resolve_tag_i]),
    .resolve_taken_i  (resolve_taken_i),
    .resolve_target_i (resolve_target_i),
    .accept_o         (accept),
    .mispredict_o     (misp),
    .ghr_o            (chk_ghr),
    .pc_o             (chk_pc),
    .upd_o            (upd)
  );
  assign hidx = head_q[TAG_BITS-1:0];
  assign tidx = tail_q[TAG_BITS-1:0];
  assign rage = resolve_tag_i - hidx;
  assign acc = resolve_valid_i & accept;
  assign mp = acc & misp;
  assign pop = ent_q[hidx].valid & ent_q[hidx].resolved;
  assign alloc_ready_o = (tail_q - head_q) != PW'(DEPTH);
  assign alloc_tag_o = tidx;
  always_comb begin
    ent_d = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    if (acc) ent_d[resolve_tag_i] = upd;
    if (pop) begin
      ent_d[hidx].valid = 1'b0;
      head_d = head_q + PW'(1);
    end
    if (mp) begin
      for (int i = 0; i < DEPTH; i++)
        if (TAG_BITS'(i) - hidx > rage) ent_d[i].valid = 1'b0;
      tail_d = head_q + {1'b0, rage} + PW'(1);
    end else if (alloc_valid_i && alloc_ready_o) begin
      ent_d[tidx] = '{valid: 1'b1, resolved: 1'b0, pc: alloc_pc_i, pred_taken: alloc_pred_taken_i,
                      pred_target: alloc_pred_target_i, ghr: alloc_ghr_snapshot_i,
                      act_taken: 1'b0, act_target: '0};
      tail_d = tail_q + PW'(1);
    end
    train_valid_d = pop;
    train_pc_d = pop ? ent_q[hidx].pc : train_pc_q;
    train_taken_d = pop ? ent_q[hidx].act_taken : train_taken_q;
    train_target_d = pop ? ent_q[hidx].act_target : train_target_q;
    train_ghr_d = pop ? ent_q[hidx].ghr : train_ghr_q;
    rec_pulse_d = mp;
    rec_ghr_d = mp ? chk_ghr : rec_ghr_q;
    rec_pc_d = mp ? chk_pc : rec_pc_q;
    rec_tag_d = mp ? resolve_tag_i : rec_tag_q;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      train_valid_q <= 1'b0;
      train_pc_q <= '0;
      train_taken_q <= 1'b0;
      train_target_q <= '0;
      train_ghr_q <= '0;
      rec_pulse_q <= 1'b0;
      rec_ghr_q <= '0;
      rec_pc_q <= '0;
      rec_tag_q <= '0;
    end else begin
      ent_q <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      train_valid_q <= train_valid_d;
      train_pc_q <= train_pc_d;
      train_taken_q <= train_taken_d;
      train_target_q <= train_target_d;
      train_ghr_q <= train_ghr_d;
      rec_pulse_q <= rec_pulse_d;
      rec_ghr_q <= rec_ghr_d;
      rec_pc_q <= rec_pc_d;
      rec_tag_q <= rec_tag_d;
    end
  end
  assign train_valid_o = train_valid_q;
  assign train_pc_o = train_pc_q;
  assign train_actual_taken_o = train_taken_q;
  assign train_actual_target_o = train_target_q;
  assign train_ghr_snapshot_o = train_ghr_q;
  assign recover_mispredict_pulse_o = rec_pulse_q;
  assign recover_ghr_snapshot_o = rec_ghr_q;
  assign recover_pc_o = rec_pc_q;
  assign recover_tag_o = rec_tag_q;
endmodule
